// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - LSU state encoding and funct3 size/sign codes shared with the decoder.
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - Combinational store lane replication/strobes, load extract/extend,
// and misalignment/illegal-funct3 detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        wen,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] load_data,
  output logic        access_err
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shifted  = mem_rdata >> {offset, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = shifted[15:0];

  // Narrow stores are replicated across lanes; the strobes pick the live bytes.
  always_comb begin
    mem_wdata = 32'd0;
    mem_wstrb = 4'd0;
    if (wen) begin
      case (funct3)
        FUNCT3_B: begin
          mem_wdata = {4{wdata[7:0]}};
          mem_wstrb = 4'b0001 << offset;
        end
        FUNCT3_H: begin
          mem_wdata = {2{wdata[15:0]}};
          mem_wstrb = 4'b0011 << offset;
        end
        FUNCT3_W: begin
          mem_wdata = wdata;
          mem_wstrb = 4'b1111;
        end
        default: begin
          mem_wdata = 32'd0;
          mem_wstrb = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    load_data = 32'd0;
    case (funct3)
      FUNCT3_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
      FUNCT3_H:  load_data = {{16{half_sel[15]}}, half_sel};
      FUNCT3_W:  load_data = mem_rdata;
      FUNCT3_BU: load_data = {24'd0, byte_sel};
      FUNCT3_HU: load_data = {16'd0, half_sel};
      default:   load_data = 32'd0;
    endcase
  end

  // Unsigned sizes only exist for loads.
  always_comb begin
    access_err = 1'b1;
    case (funct3)
      FUNCT3_B:  access_err = 1'b0;
      FUNCT3_H:  access_err = offset[0];
      FUNCT3_W:  access_err = (offset != 2'b00);
      FUNCT3_BU: access_err = wen;
      FUNCT3_HU: access_err = wen | offset[0];
      default:   access_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - Load/store unit: request capture, bus handshake FSM, timeout abort,
// and one-cycle completion pulse back to the sequencer.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lsu_reqValid,
  input  logic        lsu_wen,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        lsu_respValid,
  output logic        lsu_err,
  output logic [31:0] rdata,
  output logic        mem_reqValid,
  input  logic        mem_reqReady,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          wen_q, wen_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          idle;
  logic          timeout;
  logic [2:0]    al_funct3;
  logic          al_wen;
  logic [1:0]    al_offset;
  logic [31:0]   al_wdata;
  logic [31:0]   al_mem_wdata;
  logic [3:0]    al_mem_wstrb;
  logic [31:0]   al_load;
  logic          al_err;

  assign idle    = (state_q == LSU_IDLE);
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // In IDLE the aligner checks the incoming request so errors resolve at capture.
  assign al_funct3 = idle ? funct3     : funct3_q;
  assign al_wen    = idle ? lsu_wen    : wen_q;
  assign al_offset = idle ? addr[1:0]  : addr_q[1:0];
  assign al_wdata  = idle ? wdata      : wdata_q;

  lsu_align u_align (
    .funct3     (al_funct3),
    .wen        (al_wen),
    .offset     (al_offset),
    .wdata      (al_wdata),
    .mem_rdata  (mem_rdata),
    .mem_wdata  (al_mem_wdata),
    .mem_wstrb  (al_mem_wstrb),
    .load_data  (al_load),
    .access_err (al_err)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    wen_d    = wen_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    case (state_q)
      LSU_IDLE: begin
        if (lsu_reqValid) begin
          addr_d   = addr;
          wdata_d  = wdata;
          funct3_d = funct3;
          wen_d    = lsu_wen;
          cnt_d    = '0;
          err_d    = al_err;
          state_d  = al_err ? LSU_RESP : LSU_REQ;
        end
      end
      LSU_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (timeout) begin
          err_d   = 1'b1;
          state_d = LSU_RESP;
        end else if (mem_reqReady) begin
          state_d = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A response on the final allowed cycle still completes the access.
        if (mem_respValid) begin
          err_d   = 1'b0;
          state_d = LSU_RESP;
          if (!wen_q) begin
            rdata_d = al_load;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = LSU_RESP;
        end
      end
      LSU_RESP: begin
        state_d = LSU_IDLE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= LSU_IDLE;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      wen_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      wen_q    <= wen_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign lsu_respValid = (state_q == LSU_RESP);
  assign lsu_err       = (state_q == LSU_RESP) & err_q;
  assign rdata         = rdata_q;

  assign mem_reqValid  = (state_q == LSU_REQ);
  assign mem_addr      = mem_reqValid ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wen       = mem_reqValid & wen_q;
  assign mem_wdata     = mem_reqValid ? al_mem_wdata : 32'd0;
  assign mem_wstrb     = mem_reqValid ? al_mem_wstrb : 4'd0;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - Self-checking bench for lsu: directed vector table, multi-cycle corner
// sequences and randomized accesses against a behavioural model.
module tb_lsu;

  localparam int TO = 8;

  logic        clock;
  logic        reset;
  logic        lsu_reqValid;
  logic        lsu_wen;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        lsu_respValid;
  logic        lsu_err;
  logic [31:0] rdata;
  logic        mem_reqValid;
  logic        mem_reqReady;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_respValid;
  logic [31:0] mem_rdata;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clock         (clock),
    .reset         (reset),
    .lsu_reqValid  (lsu_reqValid),
    .lsu_wen       (lsu_wen),
    .funct3        (funct3),
    .addr          (addr),
    .wdata         (wdata),
    .lsu_respValid (lsu_respValid),
    .lsu_err       (lsu_err),
    .rdata         (rdata),
    .mem_reqValid  (mem_reqValid),
    .mem_reqReady  (mem_reqReady),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_respValid (mem_respValid),
    .mem_rdata     (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   checks = 0;
  int   failures = 0;
  logic tb_busy = 1'b0;

  always @(posedge clock) begin
    assert (!(lsu_reqValid && tb_busy)) else $error("lsu_reqValid issued while an access is in flight");
  end

  typedef struct {
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] word;
    int          rdly;
    int          sdly;
    logic        e_err;
    int          e_lat;
    logic [31:0] e_rdata;
    logic        e_req;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[$];

  int          res_lat;
  logic        res_err;
  logic [31:0] res_rdata;
  logic        res_saw_req;
  logic        res_stable;
  logic        res_reqv_at_resp;
  int          res_req_cycles;
  logic [31:0] res_addr;
  logic        res_wen;
  logic [31:0] res_wdata;
  logic [3:0]  res_wstrb;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic wen, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] word, input int rdly,
                         input int sdly, input logic e_err, input int e_lat,
                         input logic [31:0] e_rdata, input logic e_req,
                         input logic [3:0] e_wstrb, input logic [31:0] e_wdata);
    vec_t v;
    v.wen = wen; v.f3 = f3; v.a = a; v.wd = wd; v.word = word;
    v.rdly = rdly; v.sdly = sdly; v.e_err = e_err; v.e_lat = e_lat;
    v.e_rdata = e_rdata; v.e_req = e_req; v.e_wstrb = e_wstrb; v.e_wdata = e_wdata;
    vecs.push_back(v);
  endtask

  // Bus responder: ready after rdly request cycles, response sdly cycles after acceptance.
  task automatic run_access(input logic wen, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] word,
                            input int rdly, input int sdly);
    int   req_n;
    int   wait_n;
    logic acc_pending;
    req_n = 0; wait_n = 0; acc_pending = 1'b0;
    res_lat = 0; res_err = 1'b0; res_rdata = 32'd0; res_saw_req = 1'b0; res_stable = 1'b1;
    res_reqv_at_resp = 1'b0; res_addr = 32'd0; res_wen = 1'b0; res_wdata = 32'd0; res_wstrb = 4'd0;
    lsu_reqValid = 1'b1; lsu_wen = wen; funct3 = f3; addr = a; wdata = wd;
    step();
    tb_busy = 1'b1;
    lsu_reqValid = 1'b0;
    lsu_wen = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    for (int k = 1; k <= 40; k++) begin
      if (lsu_respValid) begin
        res_lat = k; res_err = lsu_err; res_rdata = rdata; res_reqv_at_resp = mem_reqValid;
        break;
      end
      mem_reqReady = 1'b0; mem_respValid = 1'b0; mem_rdata = $urandom;
      if (mem_reqValid) begin
        if (!res_saw_req) begin
          res_saw_req = 1'b1;
          res_addr = mem_addr; res_wen = mem_wen; res_wdata = mem_wdata; res_wstrb = mem_wstrb;
        end else if ({mem_addr, mem_wen, mem_wdata, mem_wstrb} !== {res_addr, res_wen, res_wdata, res_wstrb}) begin
          res_stable = 1'b0;
        end
        req_n++;
        if (req_n > rdly) begin
          mem_reqReady = 1'b1;
          acc_pending = 1'b1;
        end
      end else if (acc_pending) begin
        wait_n++;
        if (wait_n > sdly) begin
          mem_respValid = 1'b1;
          mem_rdata = word;
        end
      end
      step();
    end
    res_req_cycles = req_n;
    mem_reqReady = 1'b0; mem_respValid = 1'b0;
    step();
    tb_busy = 1'b0;
  endtask

  function automatic int m_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic m_err(input logic wen, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    legal = (f3 <= 3'd2) || (!wen && (f3 == 3'd4 || f3 == 3'd5));
    return !legal || ((int'(a[1:0]) % m_size(f3)) != 0);
  endfunction

  function automatic logic [3:0] m_wstrb(input logic wen, input logic [2:0] f3, input logic [31:0] a);
    int lanes;
    lanes = (1 << m_size(f3)) - 1;
    return wen ? 4'(lanes << a[1:0]) : 4'h0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic wen, input logic [2:0] f3, input logic [31:0] wd);
    if (!wen) return 32'd0;
    case (m_size(f3))
      1:       return 32'(wd[7:0]) * 32'h01010101;
      2:       return 32'(wd[15:0]) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    int          nbits;
    logic [31:0] v;
    logic [31:0] mask;
    nbits = 8 * m_size(f3);
    v = word >> (8 * int'(a[1:0]));
    mask = (nbits == 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
    v = v & mask;
    if (!f3[2] && nbits < 32 && v[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  logic [31:0] exp_rd;
  logic        e_err;
  int          e_lat;

  initial begin
    reset = 1'b0; lsu_reqValid = 1'b0; lsu_wen = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    mem_reqReady = 1'b0; mem_respValid = 1'b0; mem_rdata = 32'd0;
    step(); step();
    check("rst_respValid", 32'(lsu_respValid), 32'd0);
    check("rst_err", 32'(lsu_err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_bus", {mem_reqValid, mem_wen, mem_wstrb}, 32'd0);
    check("rst_addr_wdata", mem_addr | mem_wdata, 32'd0);
    reset = 1'b1;
    step();

    //      wen   f3      addr          wdata         word          rd sd  err lat rdata         req strb   mem_wdata
    add_vec(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0, 0, 1'b0, 3, 32'hDEADBEEF, 1'b1, 4'h0, 32'h0);
    add_vec(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80112233, 0, 0, 1'b0, 3, 32'hFFFFFF80, 1'b1, 4'h0, 32'h0);
    add_vec(1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80112233, 0, 0, 1'b0, 3, 32'h00000080, 1'b1, 4'h0, 32'h0);
    add_vec(1'b1, 3'b001, 32'h0000_0202, 32'h0000ABCD, 32'h11111111, 0, 0, 1'b0, 3, 32'h00000080, 1'b1, 4'hC, 32'hABCDABCD);
    add_vec(1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h22222222, 0, 0, 1'b1, 1, 32'h00000080, 1'b0, 4'h0, 32'h0);
    add_vec(1'b1, 3'b000, 32'h0000_0301, 32'h12345678, 32'h0,        0, 0, 1'b0, 3, 32'h00000080, 1'b1, 4'h2, 32'h78787878);
    add_vec(1'b0, 3'b101, 32'h0000_0402, 32'h0,        32'h89AB0000, 0, 0, 1'b0, 3, 32'h000089AB, 1'b1, 4'h0, 32'h0);
    add_vec(1'b0, 3'b001, 32'h0000_0402, 32'h0,        32'h89AB0000, 0, 0, 1'b0, 3, 32'hFFFF89AB, 1'b1, 4'h0, 32'h0);
    add_vec(1'b1, 3'b100, 32'h0000_0000, 32'h55,       32'h0,        0, 0, 1'b1, 1, 32'hFFFF89AB, 1'b0, 4'h0, 32'h0);
    add_vec(1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 1'b1, 1, 32'hFFFF89AB, 1'b0, 4'h0, 32'h0);
    add_vec(1'b0, 3'b001, 32'h0000_0001, 32'h0,        32'h0,        0, 0, 1'b1, 1, 32'hFFFF89AB, 1'b0, 4'h0, 32'h0);
    add_vec(1'b1, 3'b010, 32'h0000_0010, 32'hCAFEF00D, 32'h0,        0, 0, 1'b0, 3, 32'hFFFF89AB, 1'b1, 4'hF, 32'hCAFEF00D);
    add_vec(1'b0, 3'b010, 32'h0000_0500, 32'h0,        32'h13579BDF, 5, 0, 1'b0, 8, 32'h13579BDF, 1'b1, 4'h0, 32'h0);
    add_vec(1'b0, 3'b010, 32'h0000_0600, 32'h0,        32'h0,        0, 100, 1'b1, 9, 32'h13579BDF, 1'b1, 4'h0, 32'h0);
    add_vec(1'b0, 3'b010, 32'h0000_0700, 32'h0,        32'h0,        100, 0, 1'b1, 9, 32'h13579BDF, 1'b1, 4'h0, 32'h0);
    add_vec(1'b0, 3'b010, 32'h0000_0704, 32'h0,        32'h0F0F0F0F, 1, 5, 1'b0, 9, 32'h0F0F0F0F, 1'b1, 4'h0, 32'h0);
    add_vec(1'b0, 3'b010, 32'h0000_0708, 32'h0,        32'hF0F0F0F0, 2, 5, 1'b1, 9, 32'h0F0F0F0F, 1'b1, 4'h0, 32'h0);

    foreach (vecs[i]) begin
      run_access(vecs[i].wen, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].word, vecs[i].rdly, vecs[i].sdly);
      check($sformatf("v%0d_lat", i), res_lat, vecs[i].e_lat);
      check($sformatf("v%0d_err", i), 32'(res_err), 32'(vecs[i].e_err));
      check($sformatf("v%0d_rdata", i), res_rdata, vecs[i].e_rdata);
      check($sformatf("v%0d_reqValid_at_resp", i), 32'(res_reqv_at_resp), 32'd0);
      check($sformatf("v%0d_bus_used", i), 32'(res_saw_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) begin
        check($sformatf("v%0d_mem_addr", i), res_addr, vecs[i].a & 32'hFFFF_FFFC);
        check($sformatf("v%0d_mem_wen", i), 32'(res_wen), 32'(vecs[i].wen));
        check($sformatf("v%0d_mem_wstrb", i), 32'(res_wstrb), 32'(vecs[i].e_wstrb));
        check($sformatf("v%0d_mem_wdata", i), res_wdata, vecs[i].e_wdata);
        check($sformatf("v%0d_req_stable", i), 32'(res_stable), 32'd1);
        if (!vecs[i].e_err) check($sformatf("v%0d_req_cycles", i), res_req_cycles, vecs[i].rdly + 1);
      end
    end

    // Stray bus response while idle must not produce a completion.
    mem_respValid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    step();
    mem_respValid = 1'b0;
    check("late_resp_idle_0", 32'(lsu_respValid), 32'd0);
    step();
    check("late_resp_idle_1", {31'd0, lsu_respValid} | 32'(rdata != 32'h0F0F0F0F), 32'd0);

    // Reset pulse while waiting on the bus.
    lsu_reqValid = 1'b1; lsu_wen = 1'b0; funct3 = 3'b010; addr = 32'h0000_0900;
    step();
    lsu_reqValid = 1'b0;
    check("rstw_in_req", 32'(mem_reqValid), 32'd1);
    mem_reqReady = 1'b1;
    step();
    mem_reqReady = 1'b0;
    check("rstw_in_wait", 32'(mem_reqValid), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("rstw_resp_err", {30'd0, lsu_respValid, lsu_err}, 32'd0);
    check("rstw_rdata", rdata, 32'd0);
    check("rstw_bus", {mem_reqValid, mem_wen, mem_wstrb}, 32'd0);
    check("rstw_addr_wdata", mem_addr | mem_wdata, 32'd0);
    step();
    reset = 1'b1;
    mem_respValid = 1'b1; mem_rdata = 32'h77777777;
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
        step();
        mem_respValid = 1'b0;
        seen = seen | lsu_respValid | mem_reqValid;
      end
      check("rstw_quiet_after", 32'(seen), 32'd0);
    end
    run_access(1'b0, 3'b010, 32'h0000_0800, 32'h0, 32'h24681357, 0, 0);
    check("post_rst_lat", res_lat, 3);
    check("post_rst_rdata", res_rdata, 32'h24681357);
    exp_rd = 32'h24681357;

    for (int n = 0; n < 80; n++) begin
      logic        wen;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] word;
      int          rdly;
      int          sdly;
      wen = 1'($urandom); f3 = 3'($urandom_range(0, 7)); a = $urandom; wd = $urandom; word = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(m_size(f3) - 1);
      rdly = $urandom_range(0, 2); sdly = $urandom_range(0, 2);
      e_err = m_err(wen, f3, a);
      if (e_err) begin
        e_lat = 1;
      end else if (rdly + 1 >= TO || rdly + sdly + 2 > TO) begin
        e_err = 1'b1; e_lat = TO + 1;
      end else begin
        e_lat = rdly + sdly + 3;
        if (!wen) exp_rd = m_load(f3, a, word);
      end
      run_access(wen, f3, a, wd, word, rdly, sdly);
      check($sformatf("r%0d_lat", n), res_lat, e_lat);
      check($sformatf("r%0d_err", n), 32'(res_err), 32'(e_err));
      check($sformatf("r%0d_rdata", n), res_rdata, exp_rd);
      if (!m_err(wen, f3, a)) begin
        check($sformatf("r%0d_mem_addr", n), res_addr, a & 32'hFFFF_FFFC);
        check($sformatf("r%0d_mem_wen", n), 32'(res_wen), 32'(wen));
        check($sformatf("r%0d_mem_wstrb", n), 32'(res_wstrb), 32'(m_wstrb(wen, f3, a)));
        check($sformatf("r%0d_mem_wdata", n), res_wdata, m_wdata(wen, f3, wd));
      end else begin
        check($sformatf("r%0d_no_bus", n), 32'(res_saw_req), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
